stream_to_sdram: RTL and testbench
==================================

# stream_to_sdram

Write bridge between the video stream Wishbone bus and the SDRAM Wishbone bus. Acts as slave on `wshb_if_stream` (driven by `hw_support`), buffers incoming 32-bit pixel words in a synchronous FIFO, and replays them as single-word Wishbone writes on `wshb_if_sdram` at consecutive addresses of a frame buffer. It replaces the constant tie-offs currently applied to both buses in `Top`.

## Interface
- `FIFO_DEPTH`, default 32: FIFO words; power of 2, ≥ 4.
- `HDISP`, default 800: pixels per line.
- `VDISP`, default 480: lines per frame.
- `BASE_ADDR`, default 32'h0: byte address of pixel 0 in SDRAM.
- `sys_clk`  in  1  system clock, 100 MHz; the only clock.
- `sys_rst`  in  1  synchronous active-high reset.
- `wshb_ifs`  slave modport  wshb_if(DATA_BYTES=4)  stream input; pixel writes.
- `wshb_ifm`  master modport  wshb_if(DATA_BYTES=4)  SDRAM output.
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is acked by SDRAM.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Slave side: request = `cyc & stb`. Write request (`we=1`) with FIFO not full → `ack=1` in the same cycle, `dat_ms` pushed. Write request with FIFO full → `ack=0` (wait state), master holds the request.
- Read request (`we=0`) → `ack=1` same cycle, `dat_sm=0`, nothing pushed.
- Slave `err=0`, `rty=0` always. `sel` ignored; the full word is stored.
- Master side: `cyc=stb=!fifo_empty`, `we=1`, `sel=4'hF`, `cti=3'b000`, `bte=2'b00`, `dat_ms`=FIFO head, `adr`=BASE_ADDR + 4·pix_idx.
- On master `ack`: pop the FIFO; pix_idx increments. Outputs must not change while `stb=1 & ack=0`.
- pix_idx range 0..HDISP·VDISP−1. Ack at HDISP·VDISP−1 → pix_idx wraps to 0 and `frame_done` pulses in the next cycle.
- Master `err`/`rty` are treated as `ack` (word dropped, address advances); no retry.
- Push and pop in the same cycle: level unchanged. Push is allowed when full only if a pop happens in the same cycle; otherwise the push is stalled.

## Timing
- Reset values: slave `ack=0`, master `cyc=stb=we=0`, `adr=BASE_ADDR`, `dat_ms=0`, `frame_done=0`, `fifo_level=0`, pix_idx=0, FIFO empty.
- Latency: word acked on the slave in cycle N → master `stb=1` with that word in cycle N+1 (FIFO empty beforehand).
- Throughput: one word per cycle in each direction when SDRAM acks every cycle.
- `fifo_level` is registered and valid one cycle after each push/pop.
- `sys_rst` mid-frame: FIFO contents are discarded and pix_idx returns to 0 on the next edge. Master `cyc` drops in that cycle even if a write is outstanding. The next frame restarts at BASE_ADDR.

## Structure
- The package `video_pkg` holds `HDISP`/`VDISP` defaults, `PIX_BYTES=4`, and the `pix_idx_t` typedef (width `$clog2(HDISP*VDISP)`).
- Sub-module `sync_fifo` (params `DATA_W`, `DEPTH`): single clock, synchronous reset. Ports: `push`, `pop`, `wdata`, `rdata`, `empty`, `full`, `level`. Uses a show-ahead head (`rdata` valid whenever `!empty`).
- The top of the block contains the Wishbone glue and the pix_idx counter.
- `Top` instantiates the block with `wshb_if_stream` as `wshb_ifs` and `wshb_if_sdram` as `wshb_ifm`, and the tie-off assigns are removed.

## Test plan
- Reset, then 3 slave writes 0xA1, 0xA2, 0xA3 with SDRAM acking every cycle → SDRAM sees writes to 0x0, 0x4, 0x8 with the same data; first `stb` one cycle after the first slave `ack`.
- SDRAM `ack` held low, 40 slave writes → 32 acked, slave `ack=0` from the 33rd, `fifo_level=32`. Release `ack` → all 40 words arrive in order.
- HDISP=4, VDISP=2, 9 writes → `frame_done` pulses once after address 0x1C is acked. The 9th word goes to address 0x0.
- Slave read request → `ack=1`, `dat_sm=0`, `fifo_level` unchanged, no SDRAM transaction.
- Assert `sys_rst` with 5 words queued and `stb=1` → the next cycle has `cyc=0`, `fifo_level=0`. A subsequent write goes to BASE_ADDR.
- Simultaneous push and pop at full (level 32) → slave `ack=1`, level stays 32, no data lost or duplicated.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video geometry defaults and helpers for the frame-buffer write path.
package video_pkg;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int PIX_BYTES  = 4;
    localparam int PIX_DATA_W = 8 * PIX_BYTES;

    typedef logic [$clog2(DEF_HDISP * DEF_VDISP)-1:0] pix_idx_t;

    // Counter width for n distinct values; a one-pixel frame still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic single-word Wishbone bus bundle with master and slave views.
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
);

    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_W-1:0]       adr;
    logic [DATA_BYTES-1:0]   sel;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [2:0]              cti;
    logic [1:0]              bte;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a show-ahead head: rdata is the oldest word whenever !empty.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_push;
    logic              w_pop;

    assign empty = (r_level == '0);
    assign full  = (r_level == LW'(DEPTH));
    assign level = r_level;
    assign rdata = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/stream_to_sdram.sv
// Accepts pixel words from the stream bus, queues them, and writes them to
// consecutive frame-buffer addresses on the SDRAM bus.
module stream_to_sdram #(
    parameter int          FIFO_DEPTH = 32,
    parameter int          HDISP      = video_pkg::DEF_HDISP,
    parameter int          VDISP      = video_pkg::DEF_VDISP,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    wshb_if.slave                         wshb_ifs,
    wshb_if.master                        wshb_ifm,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import video_pkg::*;

    localparam int                NPIX     = HDISP * VDISP;
    localparam int                PIX_W    = idx_width(NPIX);
    localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);

    logic                   w_req;
    logic                   w_slave_ack;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [PIX_DATA_W-1:0]  w_head;
    logic [PIX_W-1:0]       r_pix_idx;
    logic                   r_frame_done;
    logic                   w_unused;

    assign w_unused = ^{wshb_ifs.sel, wshb_ifs.adr, wshb_ifs.cti, wshb_ifs.bte,
                        wshb_ifm.dat_sm};

    // Slave side: reads complete immediately with zero data; writes stall only on a
    // full FIFO that is not draining in the same cycle.
    assign w_req       = wshb_ifs.cyc & wshb_ifs.stb;
    assign w_pop       = ~sys_rst & ~w_empty & (wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty);
    assign w_slave_ack = ~sys_rst & w_req & (~wshb_ifs.we | ~w_full | w_pop);
    assign w_push      = w_slave_ack & wshb_ifs.we;

    assign wshb_ifs.ack    = w_slave_ack;
    assign wshb_ifs.dat_sm = '0;
    assign wshb_ifs.err    = 1'b0;
    assign wshb_ifs.rty    = 1'b0;

    sync_fifo #(
        .DATA_W (PIX_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (wshb_ifs.dat_ms),
        .rdata   (w_head),
        .empty   (w_empty),
        .full    (w_full),
        .level   (fifo_level)
    );

    // Master side is driven purely from FIFO head and pixel index, so it holds
    // steady through SDRAM wait states.
    assign wshb_ifm.cyc    = ~w_empty;
    assign wshb_ifm.stb    = ~w_empty;
    assign wshb_ifm.we     = ~w_empty;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.dat_ms = w_empty ? '0 : w_head;
    assign wshb_ifm.adr    = BASE_ADDR + (32'(r_pix_idx) * 32'(PIX_BYTES));

    // err/rty retire the word like ack: the pixel is dropped and the address moves on.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pix_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && (r_pix_idx == PIX_LAST);
            if (w_pop) begin
                r_pix_idx <= (r_pix_idx == PIX_LAST) ? '0 : r_pix_idx + PIX_W'(1);
            end
        end
    end

    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_stream_to_sdram.sv
// Randomised bench for stream_to_sdram with a queue-based reference model checked every cycle.
module tb_stream_to_sdram;

    localparam int          DEPTH = 32;
    localparam int          HD    = 4;
    localparam int          VD    = 2;
    localparam int          NPIX  = HD * VD;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_done;
    logic [5:0] fifo_level;

    wshb_if #(.DATA_BYTES(4)) ifs ();
    wshb_if #(.DATA_BYTES(4)) ifm ();

    stream_to_sdram #(
        .FIFO_DEPTH (DEPTH),
        .HDISP      (HD),
        .VDISP      (VD),
        .BASE_ADDR  (BASE)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .wshb_ifs   (ifs),
        .wshb_ifm   (ifm),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO is a queue of words, the frame position a plain index.
    logic [31:0] mq [$];
    int          pix    = 0;
    bit          exp_fd = 1'b0;
    bit          armed  = 1'b0;

    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];
    int cyc_cnt      = 0;
    int fd_count     = 0;
    int first_sack   = -1;
    int first_stb    = -1;
    int wrap_pop_cyc = -1;
    int fd_cyc       = -1;
    int ack_mode     = 0;

    bit m_req, m_pop, m_push, m_full, m_sack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(posedge clk) if (rst) armed = 1'b1;

    // SDRAM responder; updates land 2 time units after the edge so mode changes made
    // by the main sequence at edge+1 always take effect on that same cycle.
    initial begin
        ifm.ack = 1'b0; ifm.err = 1'b0; ifm.rty = 1'b0; ifm.dat_sm = '0;
        forever begin
            int r;
            @(posedge clk); #2;
            r = $urandom_range(0, 9);
            case (ack_mode)
                0: begin ifm.ack = 1'b1; ifm.err = 1'b0; ifm.rty = 1'b0; end
                1: begin ifm.ack = 1'b0; ifm.err = 1'b0; ifm.rty = 1'b0; end
                default: begin
                    ifm.ack = (r < 5); ifm.err = (r == 5); ifm.rty = (r == 6);
                end
            endcase
        end
    end

    // Compare process: checks every output against the model, then advances the model.
    always @(negedge clk) begin
        cyc_cnt++;
        m_full = (mq.size() == DEPTH);
        m_pop  = (mq.size() != 0) && (ifm.ack || ifm.err || ifm.rty);
        m_req  = ifs.cyc && ifs.stb;
        m_sack = !rst && m_req && (!ifs.we || !m_full || m_pop);
        m_push = m_sack && ifs.we;
        if (armed) begin
            chk("s_ack",      ifs.ack, m_sack);
            chk("s_dat_sm",   ifs.dat_sm, 32'h0);
            chk("s_err_rty",  {ifs.err, ifs.rty}, 32'h0);
            chk("m_cyc",      ifm.cyc, mq.size() != 0);
            chk("m_stb",      ifm.stb, mq.size() != 0);
            chk("m_we",       ifm.we,  mq.size() != 0);
            chk("m_adr",      ifm.adr, BASE + 4 * pix);
            chk("m_dat",      ifm.dat_ms, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("m_sel",      ifm.sel, 32'hF);
            chk("m_cti_bte",  {ifm.cti, ifm.bte}, 32'h0);
            chk("fifo_level", fifo_level, mq.size());
            chk("frame_done", frame_done, exp_fd);
        end
        if (m_pop && !rst) begin
            log_adr.push_back(ifm.adr);
            log_dat.push_back(ifm.dat_ms);
        end
        if (frame_done) begin fd_count++; fd_cyc = cyc_cnt; end
        if (first_sack < 0 && ifs.ack && ifs.we && m_req) first_sack = cyc_cnt;
        if (first_stb < 0 && ifm.stb) first_stb = cyc_cnt;
        if (rst) begin
            mq.delete();
            pix    = 0;
            exp_fd = 1'b0;
        end else begin
            exp_fd = m_pop && (pix == NPIX - 1);
            if (m_pop) begin
                if (pix == NPIX - 1) wrap_pop_cyc = cyc_cnt;
                void'(mq.pop_front());
                pix = (pix + 1) % NPIX;
            end
            if (m_push) mq.push_back(ifs.dat_ms);
        end
    end

    task automatic idle();
        ifs.cyc = 1'b0; ifs.stb = 1'b0; ifs.we = 1'b0;
    endtask

    // Entered and left just after a rising edge.
    task automatic wr_word(input logic [31:0] d, input int budget, output bit ok);
        ifs.cyc = 1'b1; ifs.stb = 1'b1; ifs.we = 1'b1; ifs.dat_ms = d;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ifs.ack) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!ifm.stb && fifo_level == 0) begin done = 1'b1; break; end
        end
        chk(name, done, 1'b1);
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        bit ok;
        int l0, fd0, ackd;
        idle();
        ifs.adr = '0; ifs.sel = 4'hF; ifs.dat_ms = '0; ifs.cti = '0; ifs.bte = '0;
        ack_mode = 0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_cyc",   ifm.cyc, 1'b0);
        chk("rst_adr",   ifm.adr, 32'h0000_0100);
        chk("rst_dat",   ifm.dat_ms, 32'h0);
        chk("rst_level", fifo_level, 32'h0);
        chk("rst_fd",    frame_done, 1'b0);
        @(posedge clk); #1;

        // Three writes, SDRAM acking every cycle
        first_sack = -1; first_stb = -1; l0 = log_adr.size();
        wr_word(32'hA1, 4, ok); chk("A_wr1", ok, 1'b1);
        wr_word(32'hA2, 4, ok); chk("A_wr2", ok, 1'b1);
        wr_word(32'hA3, 4, ok); chk("A_wr3", ok, 1'b1);
        wait_drain("A_drain");
        chk("A_latency", first_stb - first_sack, 1);
        chk("A_count",   log_adr.size() - l0, 3);
        chk("A_adr0", log_adr[l0 + 0], 32'h100); chk("A_dat0", log_dat[l0 + 0], 32'hA1);
        chk("A_adr1", log_adr[l0 + 1], 32'h104); chk("A_dat1", log_dat[l0 + 1], 32'hA2);
        chk("A_adr2", log_adr[l0 + 2], 32'h108); chk("A_dat2", log_dat[l0 + 2], 32'hA3);

        // Slave read request
        ifs.cyc = 1'b1; ifs.stb = 1'b1; ifs.we = 1'b0;
        @(negedge clk);
        chk("rd_ack", ifs.ack, 1'b1);
        chk("rd_dat", ifs.dat_sm, 32'h0);
        @(posedge clk); #1; idle();
        @(negedge clk);
        chk("rd_level", fifo_level, 32'h0);
        chk("rd_no_sdram", ifm.stb, 1'b0);
        @(posedge clk); #1;

        // SDRAM stalled: 32 words fit, the 33rd waits; release drains all 40 in order
        ack_mode = 1; l0 = log_adr.size(); fd0 = fd_count; ackd = 0;
        for (int i = 0; i < 32; i++) begin
            wr_word(32'hB000_0000 + i, 4, ok);
            if (ok) ackd++;
        end
        chk("B_accepted", ackd, 32);
        ifs.cyc = 1'b1; ifs.stb = 1'b1; ifs.we = 1'b1; ifs.dat_ms = 32'hB000_0020;
        repeat (3) begin
            @(negedge clk);
            chk("B_stall_ack", ifs.ack, 1'b0);
            chk("B_full_level", fifo_level, 32);
        end
        ack_mode = 0;
        ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ifs.ack) begin ok = 1'b1; break; end
        end
        chk("B_release_ack", ok, 1'b1);
        chk("B_level_pushpop", fifo_level, 32);
        @(posedge clk); #1; idle();
        @(negedge clk);
        chk("B_level_after", fifo_level, 32);
        @(posedge clk); #1;
        for (int i = 33; i < 40; i++) begin
            wr_word(32'hB000_0000 + i, 8, ok); chk("B_wr_tail", ok, 1'b1);
        end
        wait_drain("B_drain");
        chk("B_count", log_adr.size() - l0, 40);
        for (int i = 0; i < 40; i++) begin
            chk("B_order_dat", log_dat[l0 + i], 32'hB000_0000 + i);
            chk("B_order_adr", log_adr[l0 + i], BASE + 4 * ((3 + i) % 8));
        end
        chk("B_frames", fd_count - fd0, 5);

        // Reset with five words queued and stb high
        ack_mode = 1;
        for (int i = 0; i < 5; i++) begin
            wr_word(32'hC1 + i, 4, ok); chk("R_wr", ok, 1'b1);
        end
        @(negedge clk);
        chk("R_stb_before", ifm.stb, 1'b1);
        chk("R_level_before", fifo_level, 5);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("R_cyc_after", ifm.cyc, 1'b0);
        chk("R_level_after", fifo_level, 0);
        @(posedge clk); #1;
        ack_mode = 0; l0 = log_adr.size();
        wr_word(32'hE0, 4, ok); chk("R_wr_post", ok, 1'b1);
        wait_drain("R_drain");
        chk("R_post_adr", log_adr[l0], 32'h100);
        chk("R_post_dat", log_dat[l0], 32'hE0);

        // Frame wrap from a fresh start: nine writes on a 4x2 frame
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        l0 = log_adr.size(); fd0 = fd_count;
        for (int i = 0; i < 9; i++) begin
            wr_word(32'hD0 + i, 4, ok); chk("C_wr", ok, 1'b1);
        end
        wait_drain("C_drain");
        chk("C_frames", fd_count - fd0, 1);
        chk("C_adr_last", log_adr[l0 + 7], 32'h11C);
        chk("C_adr_wrap", log_adr[l0 + 8], 32'h100);
        chk("C_dat_wrap", log_dat[l0 + 8], 32'hD8);
        chk("C_fd_timing", fd_cyc - wrap_pop_cyc, 1);

        // Random traffic: SDRAM acks/errs/retries at random, mixed reads, one mid-run reset
        ack_mode = 2;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (n == 150) begin
                rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                ifs.cyc = 1'b1; ifs.stb = 1'b1; ifs.we = 1'b0;
                @(posedge clk); #1; idle();
            end else begin
                wr_word($urandom, 400, ok); chk("X_wr", ok, 1'b1);
            end
        end
        ack_mode = 0;
        wait_drain("X_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
